// File: rtl/alu_writeback_unit.sv
// Execute/writeback stage: single-cycle ALU, 16-step shift-add multiply, and a
// restoring divider (DIVU/REMU) that is only built when ALU_DIV_EN is defined.
module alu_writeback_unit #(
    parameter int WIDTH      = 16,
    parameter int AW         = 5,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic             busy,
    output logic [AW-1:0]    Rw,
    output logic             WrEn,
    output logic [WIDTH-1:0] busW,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int CW = $clog2(MUL_CYCLES);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    typedef struct packed {
        logic [3:0]    op;
        logic [AW-1:0] rd;
    } req_t;

    state_t state, stateNext;
    req_t   req;

    logic [CW-1:0]      cnt;
    logic               lastStep;
    logic               isSingle, isMulti;
    logic [WIDTH-1:0]   aluRes;
    logic               aluC, aluV;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   mcRes;
    logic               mcC, mcV;

    logic [2*WIDTH-1:0] mulAcc, mulCand, mulAdd;
    logic [WIDTH-1:0]   mulPlier;

    assign busy     = (state != IDLE);
    assign lastStep = (cnt == CW'(MUL_CYCLES - 1));
    assign isSingle = ~op[3];

`ifdef ALU_DIV_EN
    assign isMulti = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    assign isMulti = (op == OP_MUL);
`endif

    // Single-cycle ops work straight off the input buses at the accept edge.
    always_comb begin
        aluRes = '0;
        aluC   = 1'b0;
        aluV   = 1'b0;
        sum    = '0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, busA} + {1'b0, busB};
                aluRes = sum[WIDTH-1:0];
                aluC   = sum[WIDTH];
                aluV   = (busA[WIDTH-1] == busB[WIDTH-1]) && (aluRes[WIDTH-1] != busA[WIDTH-1]);
            end
            OP_SUB: begin
                // A + ~B + 1: carry out set means no borrow.
                sum    = {1'b0, busA} + {1'b0, ~busB} + {{WIDTH{1'b0}}, 1'b1};
                aluRes = sum[WIDTH-1:0];
                aluC   = sum[WIDTH];
                aluV   = (busA[WIDTH-1] != busB[WIDTH-1]) && (aluRes[WIDTH-1] != busA[WIDTH-1]);
            end
            OP_AND: aluRes = busA & busB;
            OP_OR:  aluRes = busA | busB;
            OP_XOR: aluRes = busA ^ busB;
            OP_SLL: aluRes = busA << busB[SW-1:0];
            OP_SRL: aluRes = busA >> busB[SW-1:0];
            OP_SRA: aluRes = WIDTH'($signed(busA) >>> busB[SW-1:0]);
            default: aluRes = '0;
        endcase
    end

    assign mulAdd = mulAcc + (mulPlier[0] ? mulCand : '0);

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] remReg, quoReg, divisor, remNext, quoNext;
    logic [WIDTH:0]   trial;
    logic             ge;

    // Restoring step; a zero divisor naturally yields quotient all-ones and remainder = A.
    assign trial   = {remReg, quoReg[WIDTH-1]};
    assign ge      = (trial >= {1'b0, divisor});
    assign remNext = ge ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
    assign quoNext = {quoReg[WIDTH-2:0], ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remReg  <= '0;
            quoReg  <= '0;
            divisor <= '0;
        end else if (state == IDLE && start) begin
            remReg  <= '0;
            quoReg  <= busA;
            divisor <= busB;
        end else if (state == EXEC) begin
            remReg  <= remNext;
            quoReg  <= quoNext;
        end
    end
`endif

    always_comb begin
        mcRes = mulAdd[WIDTH-1:0];
        mcC   = |mulAdd[2*WIDTH-1:WIDTH];
        mcV   = 1'b0;
`ifdef ALU_DIV_EN
        if (req.op == OP_DIVU) begin
            mcRes = quoNext;
            mcC   = 1'b0;
            mcV   = (divisor == '0);
        end else if (req.op == OP_REMU) begin
            mcRes = remNext;
            mcC   = 1'b0;
            mcV   = (divisor == '0);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = isMulti ? EXEC : WB;
            EXEC: if (lastStep) stateNext = WB;
            WB:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req      <= '0;
            cnt      <= '0;
            mulAcc   <= '0;
            mulCand  <= '0;
            mulPlier <= '0;
            WrEn     <= 1'b0;
            err      <= 1'b0;
            Rw       <= '0;
            busW     <= '0;
            flags    <= '0;
        end else begin
            WrEn <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    req      <= '{op: op, rd: rd};
                    cnt      <= '0;
                    mulAcc   <= '0;
                    mulCand  <= {{WIDTH{1'b0}}, busA};
                    mulPlier <= busB;
                    if (isSingle) begin
                        WrEn  <= 1'b1;
                        Rw    <= rd;
                        busW  <= aluRes;
                        flags <= {aluRes[WIDTH-1], ~|aluRes, aluC, aluV};
                    end else if (!isMulti) begin
                        err <= 1'b1;
                    end
                end
                EXEC: begin
                    cnt      <= cnt + 1'b1;
                    mulAcc   <= mulAdd;
                    mulCand  <= mulCand << 1;
                    mulPlier <= mulPlier >> 1;
                    if (lastStep) begin
                        WrEn  <= 1'b1;
                        Rw    <= req.rd;
                        busW  <= mcRes;
                        flags <= {mcRes[WIDTH-1], ~|mcRes, mcC, mcV};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_writeback_unit.sv
// Directed bench for alu_writeback_unit: expected writes go into a scoreboard
// queue and a negedge monitor pops/compares every WrEn and err pulse.
module tb_alu_writeback_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [4:0]  rd = '0;
    logic [15:0] busA = '0, busB = '0;
    logic        busy, WrEn, err;
    logic [4:0]  Rw;
    logic [15:0] busW;
    logic [3:0]  flags;

    alu_writeback_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rd(rd),
        .busA(busA), .busB(busB), .busy(busy), .Rw(Rw), .WrEn(WrEn),
        .busW(busW), .flags(flags), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [15:0] data;
        logic [3:0]  fl;
    } wr_t;

    wr_t expQ[$];
    int  errPending = 0;
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && WrEn) begin
            if (expQ.size() == 0) begin
                chk("unexpected_write", {11'd0, Rw, busW}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                chk("wr_rw", 32'(Rw), 32'(e.rd));
                chk("wr_busW", 32'(busW), 32'(e.data));
                chk("wr_flags", 32'(flags), 32'(e.fl));
            end
        end
        if (rst && err) begin
            if (errPending == 0) chk("unexpected_err", 32'(err), 32'd0);
            else begin
                checks++;
                errPending--;
            end
        end
    end

    task automatic drive(input logic [3:0] o, input logic [4:0] r, input logic [15:0] a, input logic [15:0] b);
        start = 1'b1; op = o; rd = r; busA = a; busB = b;
    endtask

    task automatic push(input logic [4:0] r, input logic [15:0] d, input logic [3:0] f);
        wr_t e;
        e.rd = r; e.data = d; e.fl = f;
        expQ.push_back(e);
    endtask

    task automatic waitIdle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic illegal(input logic [3:0] o, input logic [3:0] flExp, input logic [15:0] wExp);
        @(negedge clk);
        drive(o, 5'd6, 16'h0001, 16'h0001);
        errPending++;
        @(posedge clk); #1;
        chk("illegal_err_hi", 32'(err), 32'd1);
        chk("illegal_busy_hi", 32'(busy), 32'd1);
        chk("illegal_no_wren", 32'(WrEn), 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("illegal_err_lo", 32'(err), 32'd0);
        chk("illegal_busy_lo", 32'(busy), 32'd0);
        chk("illegal_flags_hold", 32'(flags), 32'(flExp));
        chk("illegal_busW_hold", 32'(busW), 32'(wExp));
    endtask

    task automatic runMulti(input logic [3:0] o, input logic [4:0] r, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] d, input logic [3:0] f);
        @(negedge clk);
        drive(o, r, a, b);
        push(r, d, f);
        @(posedge clk); #1;
        start = 1'b0;
        waitIdle(40);
    endtask

    initial begin
        int busyCnt;
        // Reset
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {WrEn, err, Rw, busW, flags}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_wren", 32'(WrEn), 32'd0);

        // ADD 0x7FFF + 1 -> 0x8000, N=1 V=1
        @(negedge clk);
        drive(4'b0000, 5'd5, 16'h7FFF, 16'h0001);
        push(5'd5, 16'h8000, 4'b1001);
        @(posedge clk); #1;
        chk("add_wren_e0", 32'(WrEn), 32'd1);
        chk("add_busy_e0", 32'(busy), 32'd1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("add_wren_e1", 32'(WrEn), 32'd0);
        chk("add_busy_e1", 32'(busy), 32'd0);

        // SUB 3-3 then SRA with start held: second write lands at E2
        @(negedge clk);
        drive(4'b0001, 5'd31, 16'h0003, 16'h0003);
        push(5'd31, 16'h0000, 4'b0110);
        @(posedge clk); #1;
        drive(4'b0111, 5'd2, 16'h8000, 16'h0004);
        push(5'd2, 16'hF800, 4'b1000);
        @(posedge clk); #1;
        chk("b2b_gap_wren", 32'(WrEn), 32'd0);
        @(posedge clk); #1;
        chk("b2b_e2_wren", 32'(WrEn), 32'd1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_done_busy", 32'(busy), 32'd0);

        // Illegal op leaves write port and flags untouched
        illegal(4'b1111, 4'b1000, 16'hF800);

        // MUL 0x0123 * 0x0010 with a stray start pulse at E3
        @(negedge clk);
        drive(4'b1000, 5'd7, 16'h0123, 16'h0010);
        push(5'd7, 16'h1230, 4'b0000);
        @(posedge clk); #1;
        start = 1'b0;
        busyCnt = busy ? 1 : 0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            if (busy) busyCnt++;
            if (k == 2) drive(4'b0000, 5'd9, 16'h0001, 16'h0001);
            if (k == 3) start = 1'b0;
            if (k == 15) chk("mul_wren_e15", 32'(WrEn), 32'd0);
            if (k == 16) chk("mul_wren_e16", 32'(WrEn), 32'd1);
            if (k == 17) chk("mul_wren_e17", 32'(WrEn), 32'd0);
        end
        chk("mul_busy_cycles", 32'(busyCnt), 32'd17);

        // MUL aborted by reset at E8, then ADD 1+1 on first edge after release
        @(negedge clk);
        drive(4'b1000, 5'd8, 16'hFFFF, 16'h0002);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_busW", 32'(busW), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0000, 5'd3, 16'h0001, 16'h0001);
        push(5'd3, 16'h0002, 4'b0000);
        @(posedge clk); #1;
        chk("post_rst_wren", 32'(WrEn), 32'd1);
        start = 1'b0;
        repeat (20) @(posedge clk);

`ifdef ALU_DIV_EN
        runMulti(4'b1001, 5'd10, 16'd100, 16'd7, 16'd14, 4'b0000);
        runMulti(4'b1010, 5'd11, 16'd100, 16'd7, 16'd2, 4'b0000);
        runMulti(4'b1001, 5'd12, 16'h1234, 16'h0000, 16'hFFFF, 4'b1001);
`else
        illegal(4'b1001, 4'b0000, 16'h0002);
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(expQ.size()), 32'd0);
        chk("err_pending_empty", 32'(errPending), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
